// File: rtl/fifo_pkg.sv
// Shared sizing for the byte FIFO and a helper for the pointer-based full test.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 6;
  localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  // Full when the addresses match but the wrap bits differ.
  function automatic logic ptr_full(ptr_t wptr, ptr_t rptr);
    return (wptr[FIFO_ADDR_WIDTH-1:0] == rptr[FIFO_ADDR_WIDTH-1:0]) &&
           (wptr[FIFO_ADDR_WIDTH] != rptr[FIFO_ADDR_WIDTH]);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] fifo_in;
  logic [DATA_WIDTH-1:0] fifo_out;
  logic                  fifo_full;
  logic                  fifo_empty;

  modport master (
    output wr_en, rd_en, fifo_in,
    input  fifo_out, fifo_full, fifo_empty
  );

  modport slave (
    input  wr_en, rd_en, fifo_in,
    output fifo_out, fifo_full, fifo_empty
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read with its own enable.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; array contents are left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, flags from registered pointers, gated accepts.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic                  full, empty;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                 (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  // Reset wins over both requests in the same cycle.
  assign wr_accept = bus.wr_en && !full && !rst;
  assign rd_accept = bus.rd_en && !empty && !rst;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_accept) begin
      wptr_d = wptr_q + PtrWidth'(1);
    end
    if (rd_accept) begin
      rptr_d = rptr_q + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
    .wr_data (bus.fifo_in),
    .rd_en   (rd_accept),
    .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  assign bus.fifo_out   = rd_data;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue reference for streaming phases.
module tb_sync_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] q[$];
  logic [7:0] exp_out;

  sync_fifo_if bus ();

  sync_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic: predict from the queue, advance, compare all outputs.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic was_full;
    logic was_empty;
    was_full  = (q.size() == 64);
    was_empty = (q.size() == 0);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.fifo_in = d;
    if (r && !was_empty) exp_out = q.pop_front();
    if (w && !was_full) q.push_back(d);
    step();
    check("out", {24'd0, bus.fifo_out}, {24'd0, exp_out});
    check("empty", {31'd0, bus.fifo_empty}, {31'd0, q.size() == 0});
    check("full", {31'd0, bus.fifo_full}, {31'd0, q.size() == 64});
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    q.delete();
    exp_out = 8'h00;
    check("rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
    check("rst_full", {31'd0, bus.fifo_full}, 32'd0);
    check("rst_out", {24'd0, bus.fifo_out}, 32'h00);
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_out     = 8'h00;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.fifo_in = 8'h00;

    do_reset(5);

    // Fill 0x00..0x3F.
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 0) check("fill_not_empty", {31'd0, bus.fifo_empty}, 32'd0);
      if (i == 62) check("fill_not_full_62", {31'd0, bus.fifo_full}, 32'd0);
      if (i == 63) check("fill_full_63", {31'd0, bus.fifo_full}, 32'd1);
    end

    // Overflow is dropped.
    cycle(1'b1, 1'b0, 8'hFF);
    check("ovf_full", {31'd0, bus.fifo_full}, 32'd1);

    // Drain in order with one-cycle latency.
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("drain_data", {24'd0, bus.fifo_out}, i);
      if (i == 0) check("drain_not_full", {31'd0, bus.fifo_full}, 32'd0);
    end
    check("drain_empty", {31'd0, bus.fifo_empty}, 32'd1);

    // Underflow holds the last value.
    cycle(1'b0, 1'b1, 8'h00);
    check("unf_hold", {24'd0, bus.fifo_out}, 32'h3F);

    // Write+read while empty: write only, no fall-through.
    cycle(1'b1, 1'b1, 8'hA5);
    check("empty_wr_rd_hold", {24'd0, bus.fifo_out}, 32'h3F);
    check("empty_wr_rd_nonempty", {31'd0, bus.fifo_empty}, 32'd0);
    cycle(1'b0, 1'b1, 8'h00);
    check("new_value", {24'd0, bus.fifo_out}, 32'hA5);

    // Half occupancy with simultaneous traffic.
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 8'(8'hC0 + i));
      check("half_data", {24'd0, bus.fifo_out},
            (i < 32) ? 32'(8'h80 + i) : 32'(8'hC0 + i - 32));
    end
    check("half_occ", q.size(), 32);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 8'h00);

    // Stream 200 bytes so both pointers wrap.
    for (int i = 0; i < 200; i++) cycle(1'b1, (i % 4) != 0, 8'((i * 7 + 3) & 8'hFF));
    while (q.size() != 0) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // Mid-operation reset with 10 entries, requests held high.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.fifo_in = 8'hEE;
    do_reset(1);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    cycle(1'b0, 1'b1, 8'h00);
    check("post_rst_unf", {24'd0, bus.fifo_out}, 32'h00);
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b0, 1'b1, 8'h00);
    check("post_rst_data", {24'd0, bus.fifo_out}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
